// File: rtl/lvds_tx_framer_if.sv
// lvds_tx_framer_if
//   Bundles the word handshake and the serializer-facing outputs of
//   lvds_tx_framer. The master side (data source / bench) drives s_data,
//   s_valid and train_req. The slave side (the framer) drives everything else.
//
//   s_data        28  word to send, lane i owns bits [i*7+6 : i*7]
//   s_valid        1  s_data valid
//   s_ready        1  FIFO can accept
//   train_req      1  single-cycle request to (re)start a training burst
//   dat_out       28  registered parallel word to the serializers
//   clk_out        7  registered forwarded-clock lane word
//   training       1  high while training words are on dat_out
//   underflow_cnt 16  saturating count of idle words inserted in RUN
interface lvds_tx_framer_if;
  logic [27:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        train_req;
  logic [27:0] dat_out;
  logic [6:0]  clk_out;
  logic        training;
  logic [15:0] underflow_cnt;

  modport master (
    output s_data, s_valid, train_req,
    input  s_ready, dat_out, clk_out, training, underflow_cnt
  );

  modport slave (
    input  s_data, s_valid, train_req,
    output s_ready, dat_out, clk_out, training, underflow_cnt
  );
endinterface

// File: rtl/lvds_tx_framer.sv
// lvds_tx_framer
//   Transmit framer for the 4-lane 7:1 DDR LVDS link, running in the
//   parallel (CLKDIV) domain. Words enter a small FIFO over valid/ready and
//   are popped one per cycle onto dat_out while in RUN. After reset, and
//   whenever train_req is seen, a burst of TRAIN_WORDS training words is
//   sent so the far end can bitslip-align. An empty FIFO in RUN inserts an
//   all-zero idle word and bumps a saturating underflow counter.
//
//   Optional build macro: LVDS_TX_PRBS_EN
//     defined   - training words come from a PRBS7 (x^7+x^6+1) generator,
//                 seed 7'h7F, reseeded on reset and at every burst start.
//     undefined - training word is the fixed 7'b1100011 on every lane.
//
//   Ports
//     clk  parallel-domain clock
//     rst  asynchronous active-high reset
//     bus  lvds_tx_framer_if.slave (handshake and serializer outputs)
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_TRAIN | emitting training words, FIFO held (writes still taken)
//   ST_RUN   | popping FIFO words, idle word on underflow
module lvds_tx_framer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TRAIN_WORDS = 64
) (
  input logic             clk,
  input logic             rst,
  lvds_tx_framer_if.slave bus
);

  localparam int              PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0]      CLK_PAT    = 7'b1100011;
  localparam logic [15:0]     TRAIN_LOAD = 16'(TRAIN_WORDS);
  localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_TRAIN = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]       r_state;
  logic [15:0]      r_train_left;
  logic [27:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_s_ready;
  logic [27:0]      r_dat_out;
  logic [6:0]       r_clk_out;
  logic             r_training;
  logic [15:0]      r_underflow;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count_next;
  logic [6:0]       w_train_word;

  // s_ready is registered, so a pop in the current cycle cannot make room
  // for a push in the same cycle; the FIFO therefore never overflows.
  assign w_push = bus.s_valid && r_s_ready;
  assign w_pop  = (r_state == ST_RUN) && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

`ifdef LVDS_TX_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic [6:0] r_prbs;
  logic [6:0] w_prbs_next;

  // Advance the LFSR seven times; each new bit is also an output bit, the
  // first one landing in bit 0 so it is serialized first.
  always_comb begin
    w_prbs_next  = r_prbs;
    w_train_word = '0;
    for (int i = 0; i < 7; i++) begin
      w_train_word[i] = w_prbs_next[6] ^ w_prbs_next[5];
      w_prbs_next     = {w_prbs_next[5:0], w_prbs_next[6] ^ w_prbs_next[5]};
    end
  end

  // A train_req restarts the burst on the next edge, so the generator is
  // reseeded there regardless of the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prbs <= PRBS_SEED;
    end else if (bus.train_req) begin
      r_prbs <= PRBS_SEED;
    end else if (r_state == ST_TRAIN) begin
      r_prbs <= w_prbs_next;
    end
  end
`else
  assign w_train_word = CLK_PAT;
`endif

  // Storage is not reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_TRAIN;
      r_train_left <= TRAIN_LOAD;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_s_ready    <= 1'b0;
      r_dat_out    <= '0;
      r_clk_out    <= '0;
      r_training   <= 1'b0;
      r_underflow  <= '0;
    end else begin
      r_clk_out <= CLK_PAT;
      r_count   <= w_count_next;
      r_s_ready <= (w_count_next != DEPTH_C);
      // Depth is a power of two, so the pointers wrap on natural overflow.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case (r_state)
        ST_TRAIN: begin
          r_dat_out  <= {4{w_train_word}};
          r_training <= 1'b1;
          if (bus.train_req) begin
            r_train_left <= TRAIN_LOAD;
          end else if (r_train_left == 16'd1) begin
            r_state <= ST_RUN;
          end else begin
            r_train_left <= r_train_left - 1'b1;
          end
        end
        default: begin
          r_training <= 1'b0;
          if (w_pop) begin
            r_dat_out <= r_mem[r_rd_ptr];
          end else begin
            r_dat_out <= '0;
            if (r_underflow != 16'hFFFF) r_underflow <= r_underflow + 1'b1;
          end
          // The word handled at this edge completes; training starts next.
          if (bus.train_req) begin
            r_state      <= ST_TRAIN;
            r_train_left <= TRAIN_LOAD;
          end
        end
      endcase
    end
  end

  assign bus.s_ready       = r_s_ready;
  assign bus.dat_out       = r_dat_out;
  assign bus.clk_out       = r_clk_out;
  assign bus.training      = r_training;
  assign bus.underflow_cnt = r_underflow;

endmodule

// File: tb/tb_lvds_tx_framer.sv
module tb_lvds_tx_framer;
  localparam int DEPTH = 4;
  localparam int TRAIN = 64;
  localparam logic [6:0] CLK_PAT = 7'b1100011;

  logic clk;
  logic rst;
  lvds_tx_framer_if bus();

  lvds_tx_framer #(.FIFO_DEPTH(DEPTH), .TRAIN_WORDS(TRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: burst of TRAIN words after reset or any train_req,
  // otherwise FIFO words in order, zero word when nothing is queued.
  logic [27:0] q[$];
  bit          m_train;
  int          m_left;
  logic [27:0] m_dat;
  logic        m_training;
  int          m_uf;
  logic        m_ready;
  logic [6:0]  m_clk;

  // k-th training word of a burst, derived from the bit stream position.
  function automatic logic [6:0] train_word(int k);
`ifdef LVDS_TX_PRBS_EN
    logic [6:0] s;
    logic [6:0] w;
    logic       b;
    s = 7'h7F;
    w = '0;
    for (int i = 0; i <= k; i++) begin
      for (int j = 0; j < 7; j++) begin
        b    = s[6] ^ s[5];
        s    = {s[5:0], b};
        w[j] = b;
      end
    end
    return w;
`else
    return (k >= 0) ? CLK_PAT : CLK_PAT;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_train    = 1'b1;
    m_left     = TRAIN;
    m_dat      = '0;
    m_training = 1'b0;
    m_uf       = 0;
    m_ready    = 1'b0;
    m_clk      = '0;
  endtask

  task automatic model_edge(input logic v, input logic [27:0] d, input logic tr);
    logic push;
    logic [6:0] tw;
    push = v && m_ready;
    if (m_train) begin
      tw         = train_word(TRAIN - m_left);
      m_dat      = {tw, tw, tw, tw};
      m_training = 1'b1;
      if (tr) m_left = TRAIN;
      else if (m_left == 1) m_train = 1'b0;
      else m_left--;
    end else begin
      m_training = 1'b0;
      if (q.size() != 0) m_dat = q.pop_front();
      else begin
        m_dat = '0;
        if (m_uf < 16'hFFFF) m_uf++;
      end
      if (tr) begin
        m_train = 1'b1;
        m_left  = TRAIN;
      end
    end
    if (push) q.push_back(d);
    m_ready = (q.size() != DEPTH);
    m_clk   = CLK_PAT;
  endtask

  task automatic compare_all();
    chk("dat_out",   {4'h0, bus.dat_out},       {4'h0, m_dat});
    chk("training",  {31'h0, bus.training},     {31'h0, m_training});
    chk("clk_out",   {25'h0, bus.clk_out},      {25'h0, m_clk});
    chk("s_ready",   {31'h0, bus.s_ready},      {31'h0, m_ready});
    chk("underflow", {16'h0, bus.underflow_cnt}, m_uf);
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next
  // falling edge. acc reports whether the word was accepted.
  task automatic step(input logic v, input logic [27:0] d, input logic tr, output logic acc);
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.train_req = tr;
    acc = v && m_ready;
    @(posedge clk);
    model_edge(v, d, tr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dat"},   {4'h0, bus.dat_out},        32'h0);
    chk({tag, "_clk"},   {25'h0, bus.clk_out},       32'h0);
    chk({tag, "_rdy"},   {31'h0, bus.s_ready},       32'h0);
    chk({tag, "_train"}, {31'h0, bus.training},      32'h0);
    chk({tag, "_uf"},    {16'h0, bus.underflow_cnt}, 32'h0);
  endtask

  initial begin
    logic        acc;
    int          cnt;
    int          got_n;
    logic [27:0] w [5];
    logic [27:0] obs [5];
    logic [27:0] got [3];

    rst           = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.train_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    rst = 1'b0;

    // First burst after reset
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      step(1'b0, '0, 1'b0, acc);
      if (bus.training) cnt++;
    end
    chk("first_burst_len", cnt, TRAIN);

    // Back-to-back streaming in RUN
    w[0] = 28'h0ABCDEF; w[1] = 28'h1234567; w[2] = 28'h7654321;
    for (int i = 0; i < 5; i++) begin
      step(i < 3, (i < 3) ? w[i] : 28'h0, 1'b0, acc);
      obs[i] = bus.dat_out;
    end
    chk("stream_w0", {4'h0, obs[1]}, {4'h0, w[0]});
    chk("stream_w1", {4'h0, obs[2]}, {4'h0, w[1]});
    chk("stream_w2", {4'h0, obs[3]}, {4'h0, w[2]});

    // Retrain while three words are queued
    step(1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      w[i] = 28'($urandom);
      step(1'b1, w[i], 1'b0, acc);
    end
    step(1'b0, '0, 1'b1, acc);
    cnt   = 0;
    got_n = 0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, '0, 1'b0, acc);
      if (bus.training) cnt++;
      else if (got_n < 3) begin
        got[got_n] = bus.dat_out;
        got_n++;
      end
    end
    chk("retrain_len", cnt, TRAIN);
    chk("retrain_q0", {4'h0, got[0]}, {4'h0, w[0]});
    chk("retrain_q1", {4'h0, got[1]}, {4'h0, w[1]});
    chk("retrain_q2", {4'h0, got[2]}, {4'h0, w[2]});

    // Randomized traffic with occasional retraining
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 28'($urandom), ($urandom_range(0, 299) == 0), acc);
    end

    // Asynchronous reset between edges with words queued
    step(1'b0, '0, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b1, 28'($urandom), 1'b0, acc);
    bus.s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks("arst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: hold TRAIN, offer five words
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 28'($urandom);
      step(1'b1, w[i], 1'b1, acc);
      if (acc) cnt++;
    end
    chk("bp_accepted", cnt, DEPTH);
    chk("bp_ready_low", {31'h0, bus.s_ready}, 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) step(1'b1, w[4], 1'b0, acc);
    chk("bp_fifth_accepted", {31'h0, acc}, 32'h1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, acc);

    // Long idle in RUN: counter saturates
    for (int i = 0; i < 70000; i++) step(1'b0, '0, 1'b0, acc);
    chk("uf_saturated", {16'h0, bus.underflow_cnt}, 32'h0000FFFF);
    chk("uf_idle_word", {4'h0, bus.dat_out}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
